// File: rtl/ad9226_capture_ctrl.sv
// AD9226 capture sequencer: arm on start, wait for a level-crossing trigger, store decimated samples.
// Optional forced trigger after TIMEOUT_CYC cycles in WAIT_TRIG: define AD9226_CAPTURE_TRIG_TIMEOUT_EN.

module ad9226_capture_ctrl #(
  parameter int          DATA_W      = 13,
  parameter int          ADDR_W      = 10,
  parameter int          DEC_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [DEC_W-1:0]  cfg_decim,
  input  logic [1:0]        cfg_trig_mode,
  input  logic [DATA_W-1:0] cfg_trig_level,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              done_flag,
  output logic              trig_timed_out
);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W+1)'(1);

  state_t            state_q;
  logic [ADDR_W:0]   len_q, len_d, wcnt_q, wcnt_nxt;
  logic [DEC_W-1:0]  decim_q, decim_d, dec_cnt_q;
  logic [DEC_W:0]    dec_nxt;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] level_q, prev_q;
  logic              prev_vld_q, fin_q;
  logic              rise, fall, genuine, to_fire, dec_hit;
  logic              wr_en_q, busy_q, done_q, done_flag_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  always_comb begin
    len_d = cfg_len;
    if (cfg_len == '0)
      len_d = ONE_LEN;
    else if (cfg_len > DEPTH)
      len_d = DEPTH;
    decim_d = (cfg_decim == '0) ? DEC_W'(1) : cfg_decim;
    rise = prev_vld_q && (prev_q < level_q) && (adc_data >= level_q);
    fall = prev_vld_q && (prev_q > level_q) && (adc_data <= level_q);
    genuine = 1'b0;
    case (mode_q)
      2'b00:   genuine = 1'b1;
      2'b01:   genuine = rise;
      2'b10:   genuine = fall;
      default: genuine = rise | fall;
    endcase
    // compare one bit wider so a counter at all-ones never wraps before matching
    dec_nxt  = {1'b0, dec_cnt_q} + (DEC_W+1)'(1);
    dec_hit  = (dec_nxt == {1'b0, decim_q});
    wcnt_nxt = wcnt_q + ONE_LEN;
  end

`ifdef AD9226_CAPTURE_TRIG_TIMEOUT_EN
  localparam int            TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt_q;
  logic            tto_q;

  // held at zero outside WAIT_TRIG, so every arm starts a fresh count; saturates at TO_MAX
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      to_cnt_q <= '0;
    else if (state_q != WAIT_TRIG)
      to_cnt_q <= '0;
    else if ((mode_q != 2'b00) && (to_cnt_q != TO_MAX))
      to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign to_fire        = (mode_q != 2'b00) && (to_cnt_q == TO_MAX);
  assign trig_timed_out = tto_q;
`else
  localparam bit unused_timeout = (TIMEOUT_CYC != 0);
  assign to_fire        = 1'b0;
  assign trig_timed_out = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      len_q       <= ONE_LEN;
      decim_q     <= DEC_W'(1);
      mode_q      <= 2'b00;
      level_q     <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      dec_cnt_q   <= '0;
      wcnt_q      <= '0;
      fin_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_flag_q <= 1'b0;
`ifdef AD9226_CAPTURE_TRIG_TIMEOUT_EN
      tto_q       <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        fin_q       <= 1'b0;
        done_flag_q <= 1'b0;
`ifdef AD9226_CAPTURE_TRIG_TIMEOUT_EN
        tto_q       <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              len_q       <= len_d;
              decim_q     <= decim_d;
              mode_q      <= cfg_trig_mode;
              level_q     <= cfg_trig_level;
              prev_vld_q  <= 1'b0;
              wcnt_q      <= '0;
              fin_q       <= 1'b0;
              done_flag_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= WAIT_TRIG;
`ifdef AD9226_CAPTURE_TRIG_TIMEOUT_EN
              tto_q       <= 1'b0;
`endif
            end
          end
          WAIT_TRIG: begin
            if (adc_valid) begin
              prev_q     <= adc_data;
              prev_vld_q <= 1'b1;
              if (genuine || to_fire) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= '0;
                wr_data_q <= adc_data;
                wcnt_q    <= ONE_LEN;
                dec_cnt_q <= '0;
                state_q   <= CAPTURE;
`ifdef AD9226_CAPTURE_TRIG_TIMEOUT_EN
                tto_q     <= !genuine;
`endif
                if (len_q == ONE_LEN) begin
                  fin_q       <= 1'b1;
                  done_q      <= 1'b1;
                  done_flag_q <= 1'b1;
                end
              end
            end
          end
          CAPTURE: begin
            // fin_q marks the cycle the final strobe is on the bus; busy stays up through it
            if (fin_q) begin
              fin_q   <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else if (adc_valid) begin
              if (dec_hit) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= wcnt_q[ADDR_W-1:0];
                wr_data_q <= adc_data;
                wcnt_q    <= wcnt_nxt;
                dec_cnt_q <= '0;
                if (wcnt_nxt == len_q) begin
                  fin_q       <= 1'b1;
                  done_q      <= 1'b1;
                  done_flag_q <= 1'b1;
                end
              end else begin
                dec_cnt_q <= dec_nxt[DEC_W-1:0];
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_flag = done_flag_q;

endmodule

// File: tb/tb_ad9226_capture_ctrl.sv
// Randomized bench for ad9226_capture_ctrl; expected writes come from a sample-index model of the
// trigger/decimation rules. Timeout case runs only when AD9226_CAPTURE_TRIG_TIMEOUT_EN is defined.

module tb_ad9226_capture_ctrl;

  localparam int DATA_W = 13;
  localparam int ADDR_W = 10;
  localparam int DEC_W  = 16;
  localparam int TO_CYC = 50;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              sys_clk, sys_rst_n;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid, start, abort;
  logic [ADDR_W:0]   cfg_len;
  logic [DEC_W-1:0]  cfg_decim;
  logic [1:0]        cfg_trig_mode;
  logic [DATA_W-1:0] cfg_trig_level;
  logic              wr_en, busy, done, done_flag, trig_timed_out;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  ad9226_capture_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEC_W(DEC_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .start(start), .abort(abort), .cfg_len(cfg_len), .cfg_decim(cfg_decim),
    .cfg_trig_mode(cfg_trig_mode), .cfg_trig_level(cfg_trig_level),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .done_flag(done_flag), .trig_timed_out(trig_timed_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  typedef struct { int addr; int data; bit dn; bit bsy; } wr_t;
  wr_t wq[$];
  int  done_cnt  = 0;
  int  done_nowr = 0;
  int  busy_late = 0;
  bit  done_prev = 1'b0;

  always @(negedge sys_clk) begin
    if (done_prev && busy) busy_late++;
    done_prev = done;
    if (wr_en) wq.push_back('{int'(wr_addr), int'(wr_data), done, busy});
    if (done) begin
      done_cnt++;
      if (!wr_en) done_nowr++;
    end
  end

  int smp[2048];
  int voff[2048];
  int exp_q[$];
  bit exp_tto;
  int drv_cyc;
  bit scramble_en = 1'b0;

  task automatic drive_cycle(input bit v, input int d, input bit st, input bit ab);
    @(negedge sys_clk);
    drv_cyc++;
    adc_valid = v;
    adc_data  = DATA_W'(d);
    start     = st;
    abort     = ab;
    if (scramble_en) begin
      cfg_len        = (ADDR_W+1)'($urandom);
      cfg_decim      = DEC_W'($urandom);
      cfg_trig_mode  = 2'($urandom);
      cfg_trig_level = DATA_W'($urandom);
    end
  endtask

  // Expected stored samples as indices into smp[], straight from the trigger/decimation rules.
  task automatic model(input int mode, input int level, input int len, input int decim,
                       input int n, input int abort_after, output int eff_len);
    int eff_dec, trig, limit, idx;
    bit r, f, g, to;
    exp_q.delete();
    exp_tto = 1'b0;
    eff_len = (len == 0) ? 1 : ((len > DEPTH) ? DEPTH : len);
    eff_dec = (decim == 0) ? 1 : decim;
    limit   = (abort_after >= 0) ? abort_after : n - 1;
    trig    = -1;
    for (int i = 0; i <= limit; i++) begin
      r = 1'b0;
      f = 1'b0;
      if (i > 0) begin
        r = (smp[i-1] < level) && (smp[i] >= level);
        f = (smp[i-1] > level) && (smp[i] <= level);
      end
      g  = (mode == 0) || (mode == 1 && r) || (mode == 2 && f) || (mode == 3 && (r || f));
      to = 1'b0;
`ifdef AD9226_CAPTURE_TRIG_TIMEOUT_EN
      to = (mode != 0) && (voff[i] >= TO_CYC + 1);
`endif
      if (g || to) begin
        trig    = i;
        exp_tto = !g;
        break;
      end
    end
    if (trig >= 0) begin
      for (int k = 0; k < eff_len; k++) begin
        idx = trig + k * eff_dec;
        if (idx <= limit) exp_q.push_back(idx);
      end
    end
    if (abort_after >= 0) exp_tto = 1'b0;
  endtask

  task automatic run_case(input string tag, input int mode, input int level, input int len,
                          input int decim, input int n, input int gap, input int abort_after,
                          input int dup_at);
    int  wq0, dc0, dn0, bl0, eff_len, n_wr, n_cmp;
    bit  complete, exp_busy;
    wq0 = wq.size(); dc0 = done_cnt; dn0 = done_nowr; bl0 = busy_late;
    scramble_en    = 1'b0;
    cfg_trig_mode  = 2'(mode);
    cfg_trig_level = DATA_W'(level);
    cfg_len        = (ADDR_W+1)'(len);
    cfg_decim      = DEC_W'(decim);
    drv_cyc        = -1;
    // a valid sample alongside start must not be used for triggering
    drive_cycle(1'b1, int'($urandom_range(0, 8191)), 1'b1, 1'b0);
    scramble_en = 1'b1;
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check_val({tag, " flag_clr"}, done_flag, 0);
    check_val({tag, " busy_arm"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) drive_cycle(1'b0, int'($urandom_range(0, 8191)), 1'b0, 1'b0);
      drive_cycle(1'b1, smp[i], 1'b0, 1'b0);
      voff[i] = drv_cyc;
      if (i == abort_after) drive_cycle(1'b0, 0, 1'b0, 1'b1);
      if (i == dup_at) drive_cycle(1'b0, 0, 1'b1, 1'b0);
    end
    repeat (6) drive_cycle(1'b0, 0, 1'b0, 1'b0);
    scramble_en = 1'b0;

    model(mode, level, len, decim, n, abort_after, eff_len);
    n_wr = wq.size() - wq0;
    check_val({tag, " nwr"}, n_wr, exp_q.size());
    n_cmp = (n_wr < exp_q.size()) ? n_wr : exp_q.size();
    for (int k = 0; k < n_cmp; k++) begin
      check_val($sformatf("%s addr%0d", tag, k), wq[wq0+k].addr, k);
      check_val($sformatf("%s data%0d", tag, k), wq[wq0+k].data, smp[exp_q[k]]);
    end
    complete = (exp_q.size() == eff_len) && (abort_after < 0);
    check_val({tag, " done_cnt"}, done_cnt - dc0, complete ? 1 : 0);
    check_val({tag, " done_nowr"}, done_nowr - dn0, 0);
    if (complete && n_wr > 0) begin
      check_val({tag, " done_w_last"}, wq[wq.size()-1].dn, 1);
      check_val({tag, " busy_last"}, wq[wq.size()-1].bsy, 1);
      check_val({tag, " busy_after"}, busy_late - bl0, 0);
    end
    check_val({tag, " done_flag"}, done_flag, complete ? 1 : 0);
    exp_busy = (abort_after < 0) && !complete;
    check_val({tag, " busy_end"}, busy, exp_busy ? 1 : 0);
    check_val({tag, " tto"}, trig_timed_out, exp_tto ? 1 : 0);
    if (exp_busy) begin
      drive_cycle(1'b0, 0, 1'b0, 1'b1);
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
      check_val({tag, " busy_clean"}, busy, 0);
    end
  endtask

  initial begin
    int mode, level, len, dec, gap, n, wq0;
    sys_rst_n = 1'b0;
    adc_valid = 1'b0; adc_data = '0; start = 1'b0; abort = 1'b0;
    cfg_len = '0; cfg_decim = '0; cfg_trig_mode = '0; cfg_trig_level = '0;
    repeat (3) @(negedge sys_clk);
    check_val("rst wr_en", wr_en, 0);
    check_val("rst wr_addr", wr_addr, 0);
    check_val("rst wr_data", wr_data, 0);
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst done_flag", done_flag, 0);
    check_val("rst tto", trig_timed_out, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 8; i++) smp[i] = i;
    run_case("ramp", 0, 0, 4, 1, 8, 4, -1, -1);

    smp[0] = 90; smp[1] = 95; smp[2] = 105; smp[3] = 110; smp[4] = 115; smp[5] = 120;
    run_case("rise1", 1, 100, 2, 1, 6, 2, -1, -1);
    smp[0] = 120; smp[1] = 80; smp[2] = 130; smp[3] = 140;
    run_case("rise2", 1, 100, 1, 1, 4, 2, -1, -1);
    smp[0] = 300; smp[1] = 250; smp[2] = 200; smp[3] = 150; smp[4] = 120;
    run_case("fall", 2, 200, 2, 1, 5, 1, -1, -1);

    for (int i = 0; i <= 20; i++) smp[i] = i;
    run_case("dec4", 0, 0, 3, 4, 21, 1, -1, -1);
    run_case("dec0", 0, 0, 3, 0, 6, 1, -1, -1);

    for (int i = 0; i < 10; i++) smp[i] = 500 + i;
    run_case("abort", 0, 0, 8, 1, 10, 2, 1, -1);
    run_case("len1", 0, 0, 1, 1, 3, 2, -1, -1);
    run_case("len0", 0, 0, 0, 1, 4, 1, -1, -1);

    for (int i = 0; i < 1030; i++) smp[i] = int'($urandom_range(0, 8191));
    run_case("len_max", 0, 0, DEPTH + 5, 1, 1030, 1, -1, 5);

    // abort wins over a simultaneous start from DONE
    wq0 = wq.size();
    cfg_trig_mode = 2'b00; cfg_len = (ADDR_W+1)'(2); cfg_decim = DEC_W'(1);
    drive_cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 7 + i, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check_val("abort_start nwr", wq.size() - wq0, 0);
    check_val("abort_start busy", busy, 0);
    check_val("abort_start done_flag", done_flag, 0);

    for (int r = 0; r < 12; r++) begin
      mode  = int'($urandom_range(0, 3));
      level = int'($urandom_range(1000, 7000));
      len   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      dec   = int'($urandom_range(0, 4));
      gap   = int'($urandom_range(1, 4));
      n     = 12 + (len + 1) * (dec + 1);
      for (int i = 0; i < n; i++)
        smp[i] = ($urandom_range(0, 7) == 0) ? level : level - 200 + int'($urandom_range(0, 399));
      run_case($sformatf("rnd%0d", r), mode, level, len, dec, n, gap, -1, -1);
    end

`ifdef AD9226_CAPTURE_TRIG_TIMEOUT_EN
    for (int i = 0; i < 20; i++) smp[i] = 10;
    run_case("timeout", 1, 100, 2, 1, 20, 4, -1, -1);
`endif

    // async reset in the middle of a capture, with a write strobe on the bus
    cfg_trig_mode = 2'b00; cfg_len = (ADDR_W+1)'(8); cfg_decim = DEC_W'(1);
    drive_cycle(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 100 + i, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check_val("mid wr_en_pre", wr_en, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_val("mid wr_en", wr_en, 0);
    check_val("mid wr_addr", wr_addr, 0);
    check_val("mid wr_data", wr_data, 0);
    check_val("mid busy", busy, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_val("post_rst busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
